fp_sqrt_post: RTL and testbench

Downstream stage of the fixed-point restoring square-root core, used in the single-precision FPU sqrt path.
- Aligns operand side-band (sign, biased result exponent, special class) with the core's fixed latency.
- Rounds the root to nearest-even, packs an IEEE-754 binary32 result, and buffers it in a small FIFO behind a valid/ready output.
- The core cannot stall, so the block also issues credits upstream to prevent FIFO overflow.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/sqrt_res_fifo.sv | 53 +++++
 rtl/fp_sqrt_post.sv | 135 +++++++++++++
 tb/tb_fp_sqrt_post.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the sqrt result path:
// class codes, special encodings and stage bundles.
package fpu_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  localparam int EXP_BIAS = 127;
  localparam int MAN_W = 23;

  typedef struct packed {
    logic       valid;
    logic       sign;
    logic [7:0] exp;
    cls_e       cls;
  } side_t;

  typedef struct packed {
    logic        inexact;
    logic [31:0] data;
  } res_t;

endpackage

// File: rtl/sqrt_res_fifo.sv
// Small synchronous FIFO for packed sqrt results.
// Simultaneous push and pop is accepted even when full.
module sqrt_res_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fp_sqrt_post.sv
// Sqrt core back end: side-band alignment, RNE rounding,
// binary32 packing, result FIFO and upstream credits.
module fp_sqrt_post
  import fpu_pkg::*;
#(
  parameter int RW = 26,
  parameter int LAT = 5,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          issue_sign,
  input  logic [7:0]    issue_exp,
  input  logic [1:0]    issue_class,
  output logic          issue_ok,
  input  logic [RW-1:0] root,
  input  logic          root_sticky,
  input  logic          root_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_inexact,
  output logic          err_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(LAT + DEPTH + 2) + 1;
  localparam int SW = IW + 1;
  localparam logic [RW-1:0] LO_MASK = {RW{1'b1}} >> 25;

  side_t dl [LAT];
  side_t dl_in;
  side_t tap;

  assign dl_in = '{
    valid: issue_valid,
    sign:  issue_sign,
    exp:   issue_exp,
    cls:   cls_e'(issue_class)
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= dl_in;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign tap = dl[LAT-1];

  logic [MAN_W-1:0] man;
  logic [MAN_W-1:0] man_r;
  logic             g;
  logic             s;
  logic             inc;
  logic             c;
  logic [7:0]       exp_r;
  logic             unused;

  // Hidden bit is implied by the normal class.
  assign unused = root[RW-1];
  assign man    = root[RW-2 -: MAN_W];
  assign g      = root[RW-25];
  assign s      = (|(root & LO_MASK)) | root_sticky;
  assign inc    = g & (s | man[0]);
  assign {c, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
  assign exp_r  = tap.exp + {7'b0, c};

  res_t pk;

  always_comb begin
    pk = '0;
    unique case (tap.cls)
      CLS_NORM: begin
        pk.data    = {tap.sign, exp_r, man_r};
        pk.inexact = g | s;
      end
      CLS_ZERO: pk.data = {tap.sign, 31'b0};
      CLS_INF:  pk.data = PINF;
      CLS_NAN:  pk.data = QNAN;
      default:  pk = '0;
    endcase
  end

  logic          acc;
  logic          proto_err;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic [SW-1:0] used;
  res_t          head;

  assign acc       = tap.valid & root_done;
  assign proto_err = tap.valid & ~root_done;
  assign drop      = acc & full & ~out_ready;

  sqrt_res_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc),
    .pop   (out_ready),
    .din   (pk),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid   = ~empty;
  assign out_data    = head.data;
  assign out_inexact = head.inexact;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      err_ovf  <= 1'b0;
    end else begin
      inflight <= inflight + IW'(issue_valid) - IW'(acc);
      if (proto_err | drop) err_ovf <= 1'b1;
    end
  end

  // Credits cover both queued results and roots still in the core.
  assign used     = SW'(count) + SW'(inflight);
  assign issue_ok = (used < SW'(DEPTH));

endmodule

// File: tb/tb_fp_sqrt_post.sv
// Randomised and directed checks of fp_sqrt_post
// against a queue-based reference model.
module tb_fp_sqrt_post;

  localparam int RW = 26;
  localparam int LAT = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_sign = 1'b0;
  logic [7:0]    issue_exp = '0;
  logic [1:0]    issue_class = '0;
  logic          issue_ok;
  logic [RW-1:0] root = '0;
  logic          root_sticky = 1'b0;
  logic          root_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_inexact;
  logic          err_ovf;

  always #5 clk = ~clk;

  fp_sqrt_post #(.RW(RW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_sign  (issue_sign),
    .issue_exp   (issue_exp),
    .issue_class (issue_class),
    .issue_ok    (issue_ok),
    .root        (root),
    .root_sticky (root_sticky),
    .root_done   (root_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact),
    .err_ovf     (err_ovf)
  );

  typedef struct {
    int            due;
    logic [RW-1:0] r;
    logic          st;
    logic [32:0]   res;
  } item_t;

  item_t       pend[$];
  logic [32:0] mq[$];
  int          inflight_m = 0;
  bit          err_m = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Reference: round root/2^(RW-24) to nearest even as a number.
  function automatic logic [32:0] ref_res(
    input logic sg, input logic [7:0] e, input logic [1:0] cl,
    input logic [RW-1:0] r, input logic st);
    longint unsigned q, rem, half;
    int sh;
    bit up;
    logic [7:0] ee;
    sh = RW - 24;
    q = longint'(r) >> sh;
    rem = longint'(r) & ((longint'(1) << sh) - 1);
    half = longint'(1) << (sh - 1);
    case (cl)
      2'd0: begin
        up = (rem > half) || (rem == half && (st || q[0]));
        q = q + longint'(up);
        ee = e;
        if (q == (longint'(1) << 24)) ee = e + 8'd1;
        return {(rem != 0) || st, sg, ee, q[22:0]};
      end
      2'd1:    return {1'b0, sg, 31'b0};
      2'd2:    return {1'b0, 32'h7F800000};
      default: return {1'b0, 32'h7FC00000};
    endcase
  endfunction

  task automatic step(input bit iv, input bit sg, input logic [7:0] e,
                      input logic [1:0] cl, input logic [RW-1:0] r,
                      input bit st);
    bit pop, acc;
    item_t it;
    issue_valid = iv;
    issue_sign  = sg;
    issue_exp   = e;
    issue_class = cl;
    acc = (pend.size() > 0) && (pend[0].due == cyc);
    root_done   = acc;
    root        = acc ? pend[0].r : RW'($urandom);
    root_sticky = acc ? pend[0].st : 1'($urandom_range(1));
    if (iv) pend.push_back('{cyc + LAT, r, st, ref_res(sg, e, cl, r, st)});
    pop = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      it = pend.pop_front();
      if (mq.size() == DEPTH) err_m = 1'b1;
      else mq.push_back(it.res);
    end
    inflight_m = inflight_m + int'(iv) - int'(acc);
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'd0, 2'd0, '0, 1'b0);
  endtask

  task automatic rnd_issue();
    step(1'b1, 1'($urandom_range(1)), 8'($urandom_range(1, 253)), 2'd0,
         {1'b1, (RW-1)'($urandom)}, 1'($urandom_range(1)));
  endtask

  task automatic dir(input string name, input bit sg, input logic [7:0] e,
                     input logic [1:0] cl, input logic [RW-1:0] r,
                     input bit st, input logic [31:0] xd, input bit xi);
    step(1'b1, sg, e, cl, r, st);
    repeat (LAT) idle();
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, xd);
    chk({name, "_inexact"}, out_inexact, xi);
    idle();
  endtask

  task automatic reset_now();
    rst = 1'b0;
    pend.delete();
    mq.delete();
    inflight_m = 0;
    err_m = 1'b0;
    issue_valid = 1'b0;
    root_done = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_issue_ok", issue_ok, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_ovf", err_ovf, 0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0][31:0]);
      chk("out_inexact", out_inexact, mq[0][32]);
    end
    chk("issue_ok", issue_ok, (mq.size() + inflight_m) < DEPTH);
    chk("err_ovf", err_ovf, err_m);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_out_inexact", out_inexact, 0);
    chk("init_issue_ok", issue_ok, 1);
    chk("init_err_ovf", err_ovf, 0);
    rst = 1'b1;
    idle();

    out_ready = 1'b1;
    dir("sqrt4", 0, 8'd128, 2'd0, 26'h2000000, 0, 32'h40000000, 0);
    dir("sqrt2", 0, 8'd127, 2'd0, 26'h2D413CC, 1, 32'h3FB504F3, 1);
    dir("tie",   0, 8'd127, 2'd0, 26'h2000006, 0, 32'h3F800002, 1);
    dir("carry", 0, 8'd127, 2'd0, 26'h3FFFFFE, 0, 32'h40000000, 1);
    dir("zero",  1, 8'd0,   2'd1, 26'h1234567, 1, 32'h80000000, 0);
    dir("inf",   0, 8'd255, 2'd2, 26'h3FFFFFF, 1, 32'h7F800000, 0);
    dir("nan",   1, 8'd255, 2'd3, 26'h2AAAAAA, 1, 32'h7FC00000, 0);

    out_ready = 1'b0;
    repeat (DEPTH) rnd_issue();
    chk("bp_issue_ok", issue_ok, 0);
    repeat (LAT + 1) idle();
    chk("bp_err_ovf", err_ovf, 0);
    chk("bp_full_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (DEPTH + 1) idle();
    chk("bp_drained", out_valid, 0);

    out_ready = 1'b0;
    repeat (DEPTH + 2) rnd_issue();
    repeat (LAT + 1) idle();
    chk("ovf_err_ovf", err_ovf, 1);
    reset_now();
    idle();

    out_ready = 1'b0;
    repeat (4) rnd_issue();
    repeat (2) idle();
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_issue_ok", issue_ok, 0);
    reset_now();
    out_ready = 1'b1;
    repeat (LAT + 2) idle();
    chk("mid_no_stale", out_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      bit ok, iv;
      logic [1:0] cl;
      out_ready = ($urandom_range(3) != 0);
      ok = (mq.size() + inflight_m) < DEPTH;
      iv = ok && ($urandom_range(1) == 1);
      cl = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd0;
      step(iv, 1'($urandom_range(1)), 8'($urandom_range(1, 253)), cl,
           {1'b1, (RW-1)'($urandom)}, 1'($urandom_range(1)));
    end
    out_ready = 1'b1;
    repeat (LAT + DEPTH + 2) idle();
    chk("final_empty", out_valid, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
